// File: rtl/wb_scoreboard_pkg.sv
// Shared definitions for the writeback scoreboard: RV32I opcodes, the NOP
// bubble and per-opcode register-usage decode.
package wb_scoreboard_pkg;

    typedef logic [4:0] reg_idx_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    function automatic logic reads_rs1(input logic [6:0] op);
        case (op)
            OP_JALR, OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_BRANCH: reads_rs1 = 1'b1;
            default:                                              reads_rs1 = 1'b0;
        endcase
    endfunction

    function automatic logic reads_rs2(input logic [6:0] op);
        case (op)
            OP_STORE, OP_REG, OP_BRANCH: reads_rs2 = 1'b1;
            default:                     reads_rs2 = 1'b0;
        endcase
    endfunction

    function automatic logic writes_rd(input logic [6:0] op);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_REG: writes_rd = 1'b1;
            default:                                                    writes_rd = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sb_tag_fifo.sv
// In-order FIFO of destination register tags for in-flight writes.
// Pointers wrap naturally; the occupancy counter is one bit wider.
module sb_tag_fifo
    import wb_scoreboard_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   push,
    input  reg_idx_t               push_rd,
    input  logic                   pop,
    output reg_idx_t               head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PW = $clog2(DEPTH);

    reg_idx_t        mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [PW:0]     cnt_q;
    logic            do_push_s;
    logic            do_pop_s;

    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;

    // Tag storage, pointers and occupancy; clr empties the queue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 5'd0;
            end
        end else if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= push_rd;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = cnt_q;
    assign full  = (cnt_q == (PW+1)'(DEPTH));
    assign empty = (cnt_q == (PW+1)'(0));

endmodule

// File: rtl/wb_scoreboard.sv
// Register scoreboard: refuses issue on RAW/WAW/full hazards by emitting a NOP
// bubble and retires destination tags in order as writebacks return.
module wb_scoreboard
    import wb_scoreboard_pkg::*;
#(
    parameter int   DEPTH  = 4,
    parameter logic FWD_WB = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue_valid,
    input  logic [31:0]            issue_instr,
    output logic                   stall,
    output logic [31:0]            instr_out,
    input  logic                   wb_valid,
    input  reg_idx_t               wb_rd,
    input  logic                   flush,
    output logic [31:0]            busy_vec,
    output logic [$clog2(DEPTH):0] inflight_cnt,
    output logic                   tag_err
);

    logic [6:0]  opcode_s;
    reg_idx_t    rs1_s, rs2_s, rd_s;
    logic [31:0] busy_q, busy_d;
    logic        tag_err_q, tag_err_d;
    reg_idx_t    fifo_head_s;
    logic        fifo_full_s, fifo_empty_s;
    logic        fwd_en_s, wr_rd_s;
    logic        haz_rs1_s, haz_rs2_s, haz_rd_s;
    logic        stall_s, accept_s, push_s, pop_s;
    logic [31:0] pop_mask_s, push_mask_s;

    function automatic logic reg_hazard(input reg_idx_t r, input logic [31:0] busy,
                                        input logic fwd_hit);
        return (r != 5'd0) && busy[r] && !fwd_hit;
    endfunction

    assign opcode_s = issue_instr[6:0];
    assign rd_s     = issue_instr[11:7];
    assign rs1_s    = issue_instr[19:15];
    assign rs2_s    = issue_instr[24:20];

    // A retiring write to the FIFO head may release that register this same cycle.
    assign fwd_en_s = FWD_WB & wb_valid & ~fifo_empty_s & (wb_rd == fifo_head_s);

    // Hazard detection, issue acceptance and next-state for busy bits and tag_err.
    always_comb begin
        haz_rs1_s   = reg_hazard(rs1_s, busy_q, fwd_en_s && (fifo_head_s == rs1_s));
        haz_rs2_s   = reg_hazard(rs2_s, busy_q, fwd_en_s && (fifo_head_s == rs2_s));
        haz_rd_s    = reg_hazard(rd_s,  busy_q, fwd_en_s && (fifo_head_s == rd_s));
        wr_rd_s     = writes_rd(opcode_s) && (rd_s != 5'd0);
        stall_s     = issue_valid && (flush
                                      || (reads_rs1(opcode_s) && haz_rs1_s)
                                      || (reads_rs2(opcode_s) && haz_rs2_s)
                                      || (wr_rd_s && (haz_rd_s || fifo_full_s)));
        accept_s    = issue_valid && !stall_s;
        push_s      = accept_s && wr_rd_s;
        pop_s       = !flush && wb_valid && !fifo_empty_s;
        pop_mask_s  = pop_s  ? (32'd1 << fifo_head_s) : 32'd0;
        push_mask_s = push_s ? (32'd1 << rd_s)        : 32'd0;
        busy_d      = flush ? 32'd0
                            : (((busy_q & ~pop_mask_s) | push_mask_s) & 32'hFFFF_FFFE);
        tag_err_d   = tag_err_q
                    || (!flush && wb_valid && (fifo_empty_s || (fifo_head_s != wb_rd)));
    end

    // Busy bits and sticky tag error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q    <= 32'd0;
            tag_err_q <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            tag_err_q <= tag_err_d;
        end
    end

    sb_tag_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr     (flush),
        .push    (push_s),
        .push_rd (rd_s),
        .pop     (pop_s),
        .head    (fifo_head_s),
        .count   (inflight_cnt),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    assign stall     = stall_s;
    assign instr_out = accept_s ? issue_instr : NOP_INSTR;
    assign busy_vec  = busy_q;
    assign tag_err   = tag_err_q;

endmodule

// File: tb/tb_wb_scoreboard.sv
// Scoreboard bench for wb_scoreboard: a queue-based reference model predicts
// each cycle's outputs and an independent monitor compares them.
module tb_wb_scoreboard;

    localparam int DEPTH = 4;
    localparam logic [6:0] OPS [10] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                                        7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011,
                                        7'b1100011, 7'b1110011};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        issue_valid = 1'b0;
    logic [31:0] issue_instr = 32'd0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = 5'd0;
    logic        flush = 1'b0;
    logic        stall;
    logic [31:0] instr_out;
    logic [31:0] busy_vec;
    logic [2:0]  inflight_cnt;
    logic        tag_err;

    typedef struct {
        logic        stall;
        logic [31:0] instr;
        logic [31:0] busy;
        int          cnt;
        logic        err;
    } exp_t;

    exp_t        exp_q [$];
    int          mq [$];
    bit          m_err;
    bit          a_wv;
    int          a_wr;
    int          n_checks = 0;
    int          n_errors = 0;
    logic        last_stall;

    wb_scoreboard #(.DEPTH(DEPTH), .FWD_WB(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_instr  (issue_instr),
        .stall        (stall),
        .instr_out    (instr_out),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .flush        (flush),
        .busy_vec     (busy_vec),
        .inflight_cnt (inflight_cnt),
        .tag_err      (tag_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // Register r is busy exactly while its tag is waiting in the model queue.
    function automatic bit m_busy(int r);
        if (r == 0) return 1'b0;
        foreach (mq[i]) if (mq[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_haz(int r);
        return m_busy(r) && !(a_wv && mq.size() > 0 && mq[0] == r && a_wr == r);
    endfunction

    function automatic logic [31:0] m_busyvec();
        logic [31:0] v = 32'd0;
        foreach (mq[i]) v[mq[i]] = 1'b1;
        return v;
    endfunction

    function automatic logic [31:0] addi(int r);
        return 32'h0000_0013 | (32'(r) << 7);
    endfunction

    // Called at posedge+1: drive, predict, then let one clock edge happen.
    task automatic cycle(bit iv, logic [31:0] ins, bit wv, int wr, bit fl);
        logic [6:0] op;
        int         rd;
        bit         wrs, acc, st;
        exp_t       e;
        issue_valid = iv; issue_instr = ins; wb_valid = wv; wb_rd = 5'(wr); flush = fl;
        a_wv = wv; a_wr = wr;
        op  = ins[6:0];
        rd  = int'(ins[11:7]);
        wrs = (op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                          7'b0000011, 7'b0010011, 7'b0110011}) && rd != 0;
        st  = iv && (fl
                     || ((op inside {7'b1100111, 7'b0000011, 7'b0100011, 7'b0010011,
                                     7'b0110011, 7'b1100011}) && m_haz(int'(ins[19:15])))
                     || ((op inside {7'b0100011, 7'b0110011, 7'b1100011})
                         && m_haz(int'(ins[24:20])))
                     || (wrs && (m_haz(rd) || mq.size() == DEPTH)));
        acc = iv && !st;
        e.stall = st;
        e.instr = acc ? ins : 32'h0000_0013;
        e.busy  = m_busyvec();
        e.cnt   = mq.size();
        e.err   = m_err;
        exp_q.push_back(e);
        #1 last_stall = stall;
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            if (wv) begin
                if (mq.size() == 0) m_err = 1'b1;
                else begin
                    if (mq[0] != wr) m_err = 1'b1;
                    void'(mq.pop_front());
                end
            end
            if (acc && wrs) mq.push_back(rd);
        end
        #1;
    endtask

    task automatic do_reset();
        issue_valid = 1'b0; wb_valid = 1'b0; flush = 1'b0;
        rst = 1'b0;
        mq.delete();
        m_err = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Monitor: compare the DUT against each predicted cycle, away from the edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("stall",        32'(stall),        32'(e.stall));
            chk("instr_out",    instr_out,         e.instr);
            chk("busy_vec",     busy_vec,          e.busy);
            chk("inflight_cnt", 32'(inflight_cnt), 32'(e.cnt));
            chk("tag_err",      32'(tag_err),      32'(e.err));
        end
    end

    initial begin
        @(posedge clk);
        #1;
        chk("reset_busy", busy_vec, 32'd0);
        chk("reset_cnt",  32'(inflight_cnt), 32'd0);
        do_reset();

        cycle(1'b1, 32'h0010_0293, 1'b0, 0, 1'b0);
        chk("addi_busy", busy_vec, 32'h20);
        chk("addi_cnt",  32'(inflight_cnt), 32'd1);
        cycle(1'b1, 32'h0052_8333, 1'b0, 0, 1'b0);
        chk("raw_stall", 32'(last_stall), 32'd1);
        cycle(1'b1, 32'h0052_8333, 1'b1, 5, 1'b0);
        chk("fwd_stall", 32'(last_stall), 32'd0);
        chk("fwd_busy",  busy_vec, 32'h40);

        cycle(1'b0, 32'd0, 1'b0, 0, 1'b1);
        for (int r = 1; r <= 4; r++) cycle(1'b1, addi(r), 1'b0, 0, 1'b0);
        cycle(1'b1, addi(7), 1'b0, 0, 1'b0);
        chk("full_stall", 32'(last_stall), 32'd1);
        chk("full_cnt",   32'(inflight_cnt), 32'd4);
        cycle(1'b1, 32'h0095_2023, 1'b0, 0, 1'b0);
        chk("store_not_full", 32'(last_stall), 32'd0);
        cycle(1'b0, 32'd0, 1'b1, 1, 1'b0);
        cycle(1'b0, 32'd0, 1'b1, 3, 1'b0);
        chk("ooo_err",  32'(tag_err), 32'd1);
        chk("ooo_busy", busy_vec, 32'h18);

        do_reset();
        cycle(1'b1, addi(1), 1'b0, 0, 1'b0);
        cycle(1'b1, addi(2), 1'b0, 0, 1'b0);
        cycle(1'b1, addi(3), 1'b1, 1, 1'b1);
        chk("flush_busy", busy_vec, 32'd0);
        chk("flush_cnt",  32'(inflight_cnt), 32'd0);
        chk("flush_err",  32'(tag_err), 32'd0);
        cycle(1'b0, 32'd0, 1'b1, 2, 1'b0);
        chk("empty_wb_err", 32'(tag_err), 32'd1);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] ins;
            bit          wv;
            int          wr;
            if (n % 100 == 0) do_reset();
            ins = {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   3'($urandom), 5'($urandom_range(0, 7)), OPS[$urandom_range(0, 9)]};
            wv = 1'b0;
            wr = 0;
            if (mq.size() > 0 && $urandom_range(0, 2) == 0) begin
                wv = 1'b1;
                wr = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : mq[0];
            end else if ($urandom_range(0, 19) == 0) begin
                wv = 1'b1;
                wr = int'($urandom_range(0, 7));
            end
            cycle($urandom_range(0, 3) != 0, ins, wv, wr, $urandom_range(0, 24) == 0);
        end

        do_reset();
        cycle(1'b1, addi(1), 1'b0, 0, 1'b0);
        for (int k = 0; k < 20; k++) cycle(1'b1, addi((k % 7) + 2), 1'b1, mq[0], 1'b0);
        chk("wrap_cnt", 32'(inflight_cnt), 32'd1);
        chk("wrap_err", 32'(tag_err), 32'd0);

        issue_valid = 1'b0; wb_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("async_busy", busy_vec, 32'd0);
        chk("async_cnt",  32'(inflight_cnt), 32'd0);
        chk("async_err",  32'(tag_err), 32'd0);
        mq.delete();
        m_err = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        cycle(1'b0, 32'd0, 1'b1, 4, 1'b0);
        chk("post_reset_wb_err", 32'(tag_err), 32'd1);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
